// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: funct codes, FSM states, single-cycle result mux.
// Latency: n/a (package, no state).
// Backpressure: n/a.
package alu_pkg;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_MFHI = 6'h10;
  localparam logic [5:0] F_MFLO = 6'h12;
  localparam logic [5:0] F_MULT = 6'h18;
  localparam logic [5:0] F_DIV  = 6'h1A;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    RESP = 2'd3
  } state_t;

  // Result of every op that completes in the accept cycle. MULT/DIV and
  // unknown codes fall through to zero: their response beat carries 0.
  function automatic logic [31:0] alu_single(
    input logic [5:0]  funct,
    input logic [4:0]  shamt,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] hi,
    input logic [31:0] lo
  );
    logic [31:0] res;
    res = 32'd0;
    case (funct)
      F_SLL:   res = a << shamt;
      F_SRL:   res = a >> shamt;
      F_MFHI:  res = hi;
      F_MFLO:  res = lo;
      F_ADD:   res = a + b;
      F_SUB:   res = a - b;
      F_AND:   res = a & b;
      F_OR:    res = a | b;
      F_XOR:   res = a ^ b;
      F_NOR:   res = ~(a | b);
      F_SLT:   res = {31'd0, (a < b)};
      default: res = 32'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_div.sv
// Radix-2 restoring unsigned divider, one quotient bit per cycle.
// Latency: start -> done pulse after DIV_CYCLES iterations + 1 cycle; divide by zero gives q=all ones, r=dividend.
// Backpressure: none; caller must hold off a new start until done.
// Ports: clk, rst_n (sync, active-low); start/dividend/divisor in; done pulse, quotient/remainder out (valid while done).
module alu_div #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam logic [5:0] LAST = 6'(DIV_CYCLES - 1);

  logic        r_run;
  logic        r_done;
  logic [5:0]  r_cnt;
  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_dvs;

  // Partial remainder shifted left with the next dividend bit; may need 33 bits.
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_sub;

  assign w_shift = {r_rem, r_quo[31]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  // When w_ge holds the true difference is below the divisor, so 32 bits suffice.
  assign w_sub   = w_shift[31:0] - r_dvs;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_run  <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= 6'd0;
      r_quo  <= 32'd0;
      r_rem  <= 32'd0;
      r_dvs  <= 32'd0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_run <= 1'b1;
        r_cnt <= 6'd0;
        r_quo <= dividend;
        r_rem <= 32'd0;
        r_dvs <= divisor;
      end else if (r_run) begin
        r_quo <= {r_quo[30:0], w_ge};
        r_rem <= w_ge ? w_sub : w_shift[31:0];
        r_cnt <= r_cnt + 6'd1;
        if (r_cnt == LAST) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign done      = r_done;
  assign quotient  = r_quo;
  assign remainder = r_rem;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops, fixed-latency multiply, optional iterative divide (macro ALU_SEQ_DIV_EN).
// Latency: 1 cycle for single-cycle ops, MUL_CYCLES+1 for mult, DIV_CYCLES+2 for div.
// Backpressure: one op in flight; in_ready low until the response beat is taken (out_valid && out_ready).
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready + funct/shamt/a/b request; out_valid/out_ready + out response; busy.
import alu_pkg::*;

module alu_seq #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic        busy
);

  localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_out;
  logic [3:0]  r_cnt;

  logic        w_accept;
  logic        w_mul_done;
  logic [63:0] w_prod;

`ifdef ALU_SEQ_DIV_EN
  logic        w_div_start;
  logic        w_div_done;
  logic        w_div_fin;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  alu_div #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (w_div_start),
    .dividend  (a),
    .divisor   (b),
    .done      (w_div_done),
    .quotient  (w_quo),
    .remainder (w_rem)
  );
`endif

  // Gated by rst_n so nothing is accepted, and ready reads low, in a reset cycle.
  assign in_ready  = rst_n && (r_state == IDLE);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == RESP);
  assign out       = r_out;
  assign busy      = (r_state == MUL) || (r_state == DIV);
  assign w_prod    = {32'd0, r_a} * {32'd0, r_b};

  always_comb begin
    w_state_nxt = r_state;
    w_mul_done  = 1'b0;
`ifdef ALU_SEQ_DIV_EN
    w_div_start = 1'b0;
    w_div_fin   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (funct == F_MULT) begin
            w_state_nxt = MUL;
          end
`ifdef ALU_SEQ_DIV_EN
          else if (funct == F_DIV) begin
            w_state_nxt = DIV;
            w_div_start = 1'b1;
          end
`endif
          else begin
            w_state_nxt = RESP;
          end
        end
      end
      MUL: begin
        if (r_cnt == MUL_LAST) begin
          w_mul_done  = 1'b1;
          w_state_nxt = RESP;
        end
      end
      DIV: begin
`ifdef ALU_SEQ_DIV_EN
        if (w_div_done) begin
          w_div_fin   = 1'b1;
          w_state_nxt = RESP;
        end
`else
        w_state_nxt = IDLE;
`endif
      end
      RESP: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a   <= 32'd0;
      r_b   <= 32'd0;
      r_hi  <= 32'd0;
      r_lo  <= 32'd0;
      r_out <= 32'd0;
      r_cnt <= 4'd0;
    end else begin
      if (w_accept) begin
        r_a   <= a;
        r_b   <= b;
        r_cnt <= 4'd0;
        r_out <= alu_single(funct, shamt, a, b, r_hi, r_lo);
      end
      if ((r_state == MUL) && !w_mul_done) begin
        r_cnt <= r_cnt + 4'd1;
      end
      // hi/lo move only here, on multi-cycle completion.
      if (w_mul_done) begin
        r_hi  <= w_prod[63:32];
        r_lo  <= w_prod[31:0];
        r_out <= 32'd0;
      end
`ifdef ALU_SEQ_DIV_EN
      if (w_div_fin) begin
        r_hi  <= w_rem;
        r_lo  <= w_quo;
        r_out <= 32'd0;
      end
`endif
    end
  end

endmodule
